mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the request/acknowledge bundle between the memory arbiter
// and the two clients, plus the memory-control strobes the arbiter drives.
//   if_req / if_ack        instruction-fetch handshake (PC-addressed read)
//   d_req / d_we / d_ack   data handshake (ALU-out-addressed read or write)
//   IorD, wea, IRWrite     memory address select, write enable, IR load enable
//   busy, state_dbg        status: not-IDLE flag and raw state encoding
// slave  = arbiter side, master = client/bench side.
interface mem_arbiter_if;
    logic       if_req;
    logic       if_ack;
    logic       d_req;
    logic       d_we;
    logic       d_ack;
    logic       IorD;
    logic       wea;
    logic       IRWrite;
    logic       busy;
    logic [2:0] state_dbg;

    modport slave (
        input  if_req, d_req, d_we,
        output if_ack, d_ack, IorD, wea, IRWrite, busy, state_dbg
    );

    modport master (
        output if_req, d_req, d_we,
        input  if_ack, d_ack, IorD, wea, IRWrite, busy, state_dbg
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// accesses. A six-state Moore FSM arbitrates only in IDLE; data normally
// wins, but after MAX_DATA_STREAK consecutive data grants taken while a
// fetch was waiting, the fetch is served so it cannot starve.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mem_arbiter_if.slave (requests in; acks, strobes, status out)
module mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_F_ADDR  = 3'd1;
    localparam logic [2:0] S_F_LOAD  = 3'd2;
    localparam logic [2:0] S_D_RADDR = 3'd3;
    localparam logic [2:0] S_D_RDONE = 3'd4;
    localparam logic [2:0] S_D_WRITE = 3'd5;

    localparam logic [1:0] STREAK_MAX = 2'(MAX_DATA_STREAK);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_streak;
    logic       w_streak_full;
    logic       w_data_grant;
    logic       w_fetch_grant;
    logic       w_if_ack;
    logic       w_d_ack;
    logic       w_iord;
    logic       w_wea;
    logic       w_irwrite;
    logic       w_busy;

    // Grant decision; only IDLE can grant, and a full streak hands a
    // contested slot to the waiting fetch.
    always_comb begin
        w_streak_full = (r_streak == STREAK_MAX);
        w_data_grant  = 1'b0;
        w_fetch_grant = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.d_req && !(bus.if_req && w_streak_full)) begin
                w_data_grant = 1'b1;
            end else if (bus.if_req) begin
                w_fetch_grant = 1'b1;
            end else begin
                w_data_grant  = 1'b0;
                w_fetch_grant = 1'b0;
            end
        end else begin
            w_data_grant  = 1'b0;
            w_fetch_grant = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Streak counter: counts data grants that made a fetch wait, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= 2'd0;
        end else if (w_fetch_grant) begin
            r_streak <= 2'd0;
        end else if (w_data_grant && bus.if_req && !w_streak_full) begin
            r_streak <= r_streak + 2'd1;
        end else begin
            r_streak <= r_streak;
        end
    end

    // Next-state logic; every transaction returns through IDLE.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_data_grant) begin
                    w_next_state = bus.d_we ? S_D_WRITE : S_D_RADDR;
                end else if (w_fetch_grant) begin
                    w_next_state = S_F_ADDR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_F_ADDR:  w_next_state = S_F_LOAD;
            S_F_LOAD:  w_next_state = S_IDLE;
            S_D_RADDR: w_next_state = S_D_RDONE;
            S_D_RDONE: w_next_state = S_IDLE;
            S_D_WRITE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Moore output decode; illegal encodings fall to the all-zero default.
    always_comb begin
        w_if_ack  = 1'b0;
        w_d_ack   = 1'b0;
        w_iord    = 1'b0;
        w_wea     = 1'b0;
        w_irwrite = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_F_ADDR: begin
                w_busy = 1'b1;
            end
            S_F_LOAD: begin
                w_irwrite = 1'b1;
                w_if_ack  = 1'b1;
                w_busy    = 1'b1;
            end
            S_D_RADDR: begin
                w_iord = 1'b1;
                w_busy = 1'b1;
            end
            S_D_RDONE: begin
                w_iord  = 1'b1;
                w_d_ack = 1'b1;
                w_busy  = 1'b1;
            end
            S_D_WRITE: begin
                w_iord  = 1'b1;
                w_wea   = 1'b1;
                w_d_ack = 1'b1;
                w_busy  = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign bus.if_ack    = w_if_ack;
    assign bus.d_ack     = w_d_ack;
    assign bus.IorD      = w_iord;
    assign bus.wea       = w_wea;
    assign bus.IRWrite   = w_irwrite;
    assign bus.busy      = w_busy;
    assign bus.state_dbg = r_state;
endmodule
